// File: rtl/fifo_burst_reader.sv
// Burst read controller: drains burst_len words from a registered-read FIFO
// onto a valid/ready stream, absorbing the read latency in a 2-entry buffer.
module fifo_burst_reader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  output logic             fifo_en_rd,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, issued_q, sent_q;
  logic             inflight_q;
  logic [WIDTH-1:0] buf_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       buf_cnt_q;

  logic             pop;
  logic             push;
  logic [2:0]       occ;

  assign pop  = m_valid & m_ready;
  assign push = inflight_q;
  // Words already owned (buffered + in flight); a pop this cycle frees a slot.
  assign occ  = {1'b0, buf_cnt_q} + {2'b00, inflight_q};

  assign fifo_en_rd = (state_q == StRun) && (issued_q < len_q) && !fifo_empty &&
                      (occ < (3'd2 + {2'b00, pop}));

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StFin);
  assign m_valid = (buf_cnt_q != 2'd0);
  assign m_data  = buf_q[rd_ptr_q];
  assign m_last  = m_valid && (sent_q == (len_q - LEN_W'(1)));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (burst_len != '0) ? StRun : StFin;
        end
      end
      StRun: begin
        if (pop && m_last) begin
          state_d = StFin;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      buf_cnt_q  <= 2'd0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_en_rd;

      if ((state_q == StIdle) && start) begin
        len_q    <= burst_len;
        issued_q <= '0;
        sent_q   <= '0;
      end else begin
        if (fifo_en_rd) begin
          issued_q <= issued_q + LEN_W'(1);
        end
        if (pop) begin
          sent_q <= sent_q + LEN_W'(1);
        end
      end

      if (push) begin
        buf_q[wr_ptr_q] <= fifo_dout;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      buf_cnt_q <= buf_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a registered-read FIFO model and
// a negedge monitor that logs reads, handshakes and done pulses.
module tb_fifo_burst_reader;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LEN_W = 4;

  logic             clk = 1'b0;
  logic             reset, start, m_ready;
  logic [LEN_W-1:0] burst_len;
  logic             busy, done, fifo_en_rd, fifo_empty, m_valid, m_last;
  logic [WIDTH-1:0] fifo_dout = '0;
  logic [WIDTH-1:0] m_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .fifo_en_rd (fifo_en_rd),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready)
  );

  // FIFO model: one-cycle registered read
  logic [WIDTH-1:0] fmem [256];
  int fwp = 0;
  int frp = 0;
  assign fifo_empty = (fwp == frp);

  always @(posedge clk) begin
    if (fifo_en_rd && (fwp != frp)) begin
      fifo_dout <= fmem[frp];
      frp       <= frp + 1;
    end
  end

  // Monitor
  int               cyc = 0;
  int               nreads = 0, nout = 0, ndone = 0, nvalid = 0;
  int               rd_cyc [256];
  logic [WIDTH-1:0] out_data [256];
  bit               out_last [256];
  int               out_cyc [256];
  int               done_cyc = 0;
  int               stall_err = 0, empty_rd_err = 0, buf_ovf = 0;
  bit               stalled = 0;
  logic [WIDTH-1:0] hold_data = '0;
  logic             hold_last = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (fifo_en_rd) begin
      rd_cyc[nreads] = cyc;
      nreads = nreads + 1;
      if (fifo_empty) empty_rd_err = empty_rd_err + 1;
    end
    if (m_valid) nvalid = nvalid + 1;
    if (m_valid && m_ready) begin
      out_data[nout] = m_data;
      out_last[nout] = m_last;
      out_cyc[nout]  = cyc;
      nout = nout + 1;
    end
    if (done) begin
      ndone = ndone + 1;
      done_cyc = cyc;
    end
    if (stalled && (!m_valid || m_data !== hold_data || m_last !== hold_last))
      stall_err = stall_err + 1;
    stalled   = m_valid && !m_ready && !reset;
    hold_data = m_data;
    hold_last = m_last;
    if (dut.buf_cnt_q > 2'd2) buf_ovf = buf_ovf + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    fmem[fwp] = w;
    fwp = fwp + 1;
  endtask

  // Pulses start for one cycle; t0 is the cycle whose closing edge accepts it.
  task automatic start_burst(input logic [LEN_W-1:0] len, output int t0);
    tick();
    start     = 1'b1;
    burst_len = len;
    t0        = cyc + 1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int d0);
    for (int i = 0; i < budget; i++) begin
      sample();
      if (ndone > d0) break;
    end
    if (ndone == d0) check("done_timeout", 32'd0, 32'd1);
  endtask

  int b, r, d, nv, t0, k;

  initial begin
    reset = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b0;
    tick();
    tick();
    sample();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_en_rd", fifo_en_rd, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_data", m_data, 0);
    tick();
    reset = 1'b0;

    // Burst of 4 with continuous ready
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    m_ready = 1'b1;
    b = nout; r = nreads; d = ndone;
    start_burst(4, t0);
    wait_done(40, d);
    check("t1_done_busy", busy, 1);
    check("t1_reads", nreads - r, 4);
    check("t1_first_rd", rd_cyc[r], t0 + 1);
    check("t1_last_rd", rd_cyc[r+3], t0 + 4);
    check("t1_nout", nout - b, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_data%0d", i), out_data[b+i], 32'h11 * (i + 1));
      check($sformatf("t1_last%0d", i), out_last[b+i], (i == 3) ? 1 : 0);
    end
    check("t1_first_out", out_cyc[b], t0 + 3);
    check("t1_last_out", out_cyc[b+3], t0 + 6);
    check("t1_done_cyc", done_cyc, t0 + 7);
    sample();
    check("t1_idle_busy", busy, 0);
    check("t1_idle_done", done, 0);

    // Same burst, m_ready pattern 1,0,0 repeating
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    b = nout; r = nreads; d = ndone; k = 0;
    start_burst(4, t0);
    for (int i = 0; i < 60 && ndone == d; i++) begin
      m_ready = (k % 3 == 0);
      k = k + 1;
      tick();
    end
    if (ndone == d) check("t2_timeout", 32'd0, 32'd1);
    check("t2_nout", nout - b, 4);
    check("t2_reads", nreads - r, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_data%0d", i), out_data[b+i], 32'h11 * (i + 1));
      check($sformatf("t2_last%0d", i), out_last[b+i], (i == 3) ? 1 : 0);
    end
    check("t2_stall_stable", stall_err, 0);
    m_ready = 1'b1;
    tick();
    tick();

    // FIFO runs dry mid-burst, refilled 6 cycles after start
    push(8'hA1); push(8'hA2);
    b = nout; r = nreads; d = ndone;
    start_burst(5, t0);
    repeat (5) tick();
    check("t3_busy_gap", busy, 1);
    push(8'hA3); push(8'hA4); push(8'hA5);
    wait_done(40, d);
    check("t3_nout", nout - b, 5);
    check("t3_reads", nreads - r, 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_data%0d", i), out_data[b+i], 32'hA1 + i);
      check($sformatf("t3_last%0d", i), out_last[b+i], (i == 4) ? 1 : 0);
    end
    check("t3_out1_cyc", out_cyc[b+1], t0 + 4);
    check("t3_out2_cyc", out_cyc[b+2], t0 + 8);
    check("t3_out4_cyc", out_cyc[b+4], t0 + 10);
    check("t3_done_cnt", ndone - d, 1);

    // Zero-length burst, with a word available to tempt a read
    push(8'h5A);
    b = nout; r = nreads; d = ndone; nv = nvalid;
    start_burst(0, t0);
    sample();
    check("t4_done", done, 1);
    check("t4_busy", busy, 1);
    check("t4_done_cyc", cyc, t0 + 1);
    sample();
    check("t4_busy_off", busy, 0);
    check("t4_done_off", done, 0);
    check("t4_reads", nreads - r, 0);
    check("t4_valid", nvalid - nv, 0);

    // start while busy is ignored
    m_ready = 1'b0;
    b = nout; r = nreads; d = ndone;
    start_burst(1, t0);
    tick();
    start = 1'b1; burst_len = 4'd2;
    tick();
    start = 1'b0;
    repeat (3) tick();
    m_ready = 1'b1;
    wait_done(20, d);
    repeat (6) sample();
    check("t4b_done_cnt", ndone - d, 1);
    check("t4b_reads", nreads - r, 1);
    check("t4b_nout", nout - b, 1);
    check("t4b_data", out_data[b], 32'h5A);
    check("t4b_last", out_last[b], 1);
    check("t4b_busy", busy, 0);

    // Reset after 2 of 6 words
    for (int i = 0; i < 6; i++) push(8'h61 + 8'(i));
    b = nout; r = nreads; d = ndone;
    start_burst(6, t0);
    for (int i = 0; i < 20 && (nout - b) < 2; i++) tick();
    if ((nout - b) < 2) check("t5_timeout", 32'd0, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sample();
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_en_rd", fifo_en_rd, 0);
    check("t5_valid", m_valid, 0);
    check("t5_last", m_last, 0);
    check("t5_data", m_data, 0);
    check("t5_no_done", ndone - d, 0);
    check("t5_reads", nreads - r, 5);
    b = nout; d = ndone;
    start_burst(1, t0);
    wait_done(20, d);
    check("t5b_nout", nout - b, 1);
    check("t5b_data", out_data[b], 32'h66);
    check("t5b_last", out_last[b], 1);

    // Maximum length burst
    for (int i = 0; i < 15; i++) push(8'h80 + 8'(i));
    b = nout; r = nreads; d = ndone;
    start_burst(15, t0);
    wait_done(80, d);
    check("t6_nout", nout - b, 15);
    check("t6_reads", nreads - r, 15);
    for (int i = 0; i < 15; i++) begin
      check($sformatf("t6_data%0d", i), out_data[b+i], 32'h80 + i);
      check($sformatf("t6_last%0d", i), out_last[b+i], (i == 14) ? 1 : 0);
    end
    check("t6_span", out_cyc[b+14] - out_cyc[b], 14);
    check("t6_fifo_empty", fifo_empty, 1);
    check("t6_done_cnt", ndone - d, 1);

    check("stall_stable_all", stall_err, 0);
    check("no_empty_reads", empty_rd_err, 0);
    check("buf_cnt_max2", buf_ovf, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
